// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared types and constants for the 3:1 round-robin mux arbiter.
package mux3_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;

  // Mux select index to the matching one-hot grant vector; 11 maps to no grant.
  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    oh = 3'b000;
    case (idx)
      SEL_IN0: oh = 3'b001;
      SEL_IN1: oh = 3'b010;
      SEL_IN2: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux3_rr_arbiter_if.sv
// Requester/consumer bus of the 3:1 mux arbiter: request+data in, grant/select and valid/data out.
interface mux3_rr_arbiter_if #(
  parameter int unsigned WIDTH = 1
);
  logic [2:0]         req;
  logic [3*WIDTH-1:0] in_data;
  logic               ready;
  logic [2:0]         grant;
  logic [1:0]         sel;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;

  modport slave (
    input  req, in_data, ready,
    output grant, sel, out_valid, out_data
  );

  modport master (
    output req, in_data, ready,
    input  grant, sel, out_valid, out_data
  );
endinterface

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// Rotating-priority picker: first set request searching from last+1, wrapping 2->0.
module rr_pick3
  import mux3_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       any
);

  always_comb begin
    win = SEL_IN0;
    any = |req;
    case (last)
      SEL_IN0: win = req[1] ? SEL_IN1 : (req[2] ? SEL_IN2 : SEL_IN0);
      SEL_IN1: win = req[2] ? SEL_IN2 : (req[0] ? SEL_IN0 : SEL_IN1);
      default: win = req[0] ? SEL_IN0 : (req[1] ? SEL_IN1 : SEL_IN2);
    endcase
  end

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 3:1 mux feeding a valid/ready consumer.
module mux3_rr_arbiter
  import mux3_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux3_rr_arbiter_if.slave  bus
);

  localparam int unsigned    CNT_W    = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             state, state_nxt;
  logic [2:0]         grant, grant_nxt;
  logic [1:0]         sel, sel_nxt;
  logic [1:0]         last, last_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;

  logic [2:0]         cand;
  logic [1:0]         win;
  logic               any;
  logic               valid;
  logic               beat;

  // Masking with the current grant yields "other requesters" in GRANT and all of req in IDLE.
  assign cand  = bus.req & ~grant;
  assign valid = |(grant & bus.req);
  assign beat  = valid & bus.ready;

  rr_pick3 u_pick (
    .req  (cand),
    .last (last),
    .win  (win),
    .any  (any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 3'b000;
      sel      <= SEL_IN0;
      last     <= SEL_IN2;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    sel_nxt      = sel;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (any) begin
          state_nxt    = GRANT;
          grant_nxt    = idx_to_onehot(win);
          sel_nxt      = win;
          last_nxt     = win;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!valid) begin
          // Owner withdrew: hand over immediately or fall back to idle.
          beat_cnt_nxt = '0;
          if (any) begin
            grant_nxt = idx_to_onehot(win);
            sel_nxt   = win;
            last_nxt  = win;
          end else begin
            state_nxt = IDLE;
            grant_nxt = 3'b000;
            sel_nxt   = SEL_IN0;
          end
        end else if (beat) begin
          if (beat_cnt == CNT_LAST) begin
            beat_cnt_nxt = '0;
            if (any) begin
              grant_nxt = idx_to_onehot(win);
              sel_nxt   = win;
              last_nxt  = win;
            end
          end else if (beat_cnt != CNT_MAX) begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
        // valid && !ready is a stall: everything holds.
      end
      default: begin
        state_nxt    = IDLE;
        grant_nxt    = 3'b000;
        sel_nxt      = SEL_IN0;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    bus.out_data = '0;
    case (sel)
      SEL_IN0: bus.out_data = bus.in_data[0*WIDTH +: WIDTH];
      SEL_IN1: bus.out_data = bus.in_data[1*WIDTH +: WIDTH];
      SEL_IN2: bus.out_data = bus.in_data[2*WIDTH +: WIDTH];
      default: bus.out_data = '0;
    endcase
  end

  assign bus.grant     = grant;
  assign bus.sel       = sel;
  assign bus.out_valid = valid;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter: vector table for rotation/handover plus hand-written corner sequences.
module tb_mux3_rr_arbiter;
  import mux3_arb_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NVEC  = 17;

  typedef struct {
    logic [2:0] req;
    logic       ready;
    logic [2:0] g;
    logic [1:0] s;
    logic       v;
    logic [7:0] d;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned sel11 = 0;
  vec_t tbl [NVEC];

  mux3_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux3_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.sel == 2'b11) sel11++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [2:0] g, input logic [1:0] s,
                           input logic v, input logic [7:0] d);
    check({name, ".grant"}, 32'(bus.grant), 32'(g));
    check({name, ".valid"}, 32'(bus.out_valid), 32'(v));
    if (g != 3'b000) begin
      check({name, ".sel"}, 32'(bus.sel), 32'(s));
      check({name, ".data"}, 32'(bus.out_data), 32'(d));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input logic rdy);
    bus.req   = r;
    bus.ready = rdy;
  endtask

  initial begin
    // Full rotation under req=111, then owner-withdraw handovers and drop to idle.
    for (int i = 0; i < 4; i++) tbl[i]     = '{3'b111, 1'b1, 3'b001, SEL_IN0, 1'b1, 8'h0F};
    for (int i = 4; i < 8; i++) tbl[i]     = '{3'b111, 1'b1, 3'b010, SEL_IN1, 1'b1, 8'h5A};
    for (int i = 8; i < 12; i++) tbl[i]    = '{3'b111, 1'b1, 3'b100, SEL_IN2, 1'b1, 8'hC3};
    tbl[12] = '{3'b111, 1'b1, 3'b001, SEL_IN0, 1'b1, 8'h0F};
    tbl[13] = '{3'b010, 1'b1, 3'b010, SEL_IN1, 1'b1, 8'h5A};
    tbl[14] = '{3'b100, 1'b1, 3'b100, SEL_IN2, 1'b1, 8'hC3};
    tbl[15] = '{3'b001, 1'b1, 3'b001, SEL_IN0, 1'b1, 8'h0F};
    tbl[16] = '{3'b000, 1'b1, 3'b000, SEL_IN0, 1'b0, 8'h00};

    bus.in_data = {8'hC3, 8'h5A, 8'h0F};
    drive(3'b111, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 3'b000, SEL_IN0, 1'b0, 8'h00);
    check("reset.sel", 32'(bus.sel), 32'(SEL_IN0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].req, tbl[i].ready);
      step();
      check_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].v, tbl[i].d);
    end

    // Async reset while in1 holds the grant.
    drive(3'b010, 1'b1);
    step();
    check_out("pre_rst", 3'b010, SEL_IN1, 1'b1, 8'h5A);
    #1 rst_n = 1'b0;
    #1;
    check_out("async_rst", 3'b000, SEL_IN0, 1'b0, 8'h00);
    check("async_rst.sel", 32'(bus.sel), 32'(SEL_IN0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b001, 1'b1);
    step();
    check_out("post_rst", 3'b001, SEL_IN0, 1'b1, 8'h0F);

    // Lone requester keeps the grant across counter wraps.
    for (int i = 0; i < 10; i++) begin
      step();
      check_out($sformatf("solo%0d", i), 3'b001, SEL_IN0, 1'b1, 8'h0F);
    end

    // Backpressure freezes grant/sel/data; rotation only on the 4th accepted beat.
    drive(3'b010, 1'b0);
    step();
    check_out("to_in1", 3'b010, SEL_IN1, 1'b1, 8'h5A);
    drive(3'b111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("stall%0d", i), 3'b010, SEL_IN1, 1'b1, 8'h5A);
    end
    drive(3'b111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("hold%0d", i), 3'b010, SEL_IN1, 1'b1, 8'h5A);
    end
    step();
    check_out("rotate", 3'b100, SEL_IN2, 1'b1, 8'hC3);

    // Owner drops: immediate handover, then idle when nobody is left.
    drive(3'b001, 1'b1);
    step();
    check_out("drop_handover", 3'b001, SEL_IN0, 1'b1, 8'h0F);
    drive(3'b100, 1'b1);
    step();
    check_out("back_to_in2", 3'b100, SEL_IN2, 1'b1, 8'hC3);
    drive(3'b000, 1'b1);
    step();
    check_out("drop_idle", 3'b000, SEL_IN0, 1'b0, 8'h00);

    check("sel_never_11", 32'(sel11), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
